turn_step_ctrl: RTL and testbench

TURN_STEP_CTRL -- requirements
Module: turn_step_ctrl

---
 rtl/turn_step_ctrl.sv | 121 ++++++++++++
 tb/tb_turn_step_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/turn_step_ctrl.sv
// Turn/step controller: emits one D strobe per board square for the current player, then advances the turn.
// Optional macro TURN_STEP_GAP_EN inserts one low GAP cycle between consecutive step strobes.
module turn_step_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] M,
  input  logic [2:0] N,
  input  logic       move_req,
  input  logic [2:0] steps,
  input  logic       keep_turn,
  output logic       D,
  output logic       p_da1,
  output logic       p_da2,
  output logic       p_da3,
  output logic       p_da4,
  output logic [1:0] turn,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] MODE_SETUP = 3'b010;

`ifdef TURN_STEP_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, ADV = 2'd2, GAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, ADV = 2'd2} state_t;
`endif

  state_t     state_q, state_d;
  logic [2:0] rem_cnt;
  logic       keep_r;
  logic [3:0] p_da;
  logic       setup;
  logic       accept;

  // Out-of-range player counts behave as a four-player game.
  function automatic logic [2:0] eff_n(input logic [2:0] n);
    return (n == 3'd2 || n == 3'd3) ? n : 3'd4;
  endfunction

  // A turn left stranded above a reduced player count falls back to player 1.
  function automatic logic [1:0] next_turn(input logic [1:0] t, input logic keep,
                                           input logic [2:0] n);
    logic [2:0] t3;
    logic [2:0] en;
    t3 = {1'b0, t};
    en = eff_n(n);
    if (t3 >= en)            return 2'd0;
    else if (keep)           return t;
    else if (t3 + 3'd1 == en) return 2'd0;
    else                     return t + 2'd1;
  endfunction

  assign setup  = (M == MODE_SETUP);
  assign accept = (state_q == IDLE) && move_req && !setup;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    D       = 1'b0;
    p_da    = 4'b0000;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (steps == 3'd0) ? ADV : STEP;
      end
      STEP: begin
        D    = 1'b1;
        p_da = 4'b0001 << turn;
`ifdef TURN_STEP_GAP_EN
        state_d = (rem_cnt == 3'd1) ? ADV : GAP;
`else
        state_d = (rem_cnt == 3'd1) ? ADV : STEP;
`endif
      end
`ifdef TURN_STEP_GAP_EN
      GAP: state_d = STEP;
`endif
      ADV: begin
        done    = !setup;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (setup) state_d = IDLE;
  end

  assign p_da1 = p_da[0];
  assign p_da2 = p_da[1];
  assign p_da3 = p_da[2];
  assign p_da4 = p_da[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turn    <= 2'd0;
      rem_cnt <= 3'd0;
      keep_r  <= 1'b0;
    end else if (setup) begin
      turn    <= 2'd0;
      rem_cnt <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rem_cnt <= steps;
            keep_r  <= keep_turn;
          end
        end
        STEP:    rem_cnt <= rem_cnt - 3'd1;
        ADV:     turn    <= next_turn(turn, keep_r, N);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_step_ctrl.sv
// Self-checking bench for turn_step_ctrl: directed scenarios plus randomized moves against a reference model.
module tb_turn_step_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] M;
  logic [2:0] N;
  logic       move_req;
  logic [2:0] steps;
  logic       keep_turn;
  logic       D, p_da1, p_da2, p_da3, p_da4, busy, done;
  logic [1:0] turn;
  logic [3:0] pda_vec;

  int checks = 0;
  int errors = 0;
  int model_turn = 0;

`ifdef TURN_STEP_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  turn_step_ctrl dut (
    .clk(clk), .rst_n(rst_n), .M(M), .N(N), .move_req(move_req), .steps(steps),
    .keep_turn(keep_turn), .D(D), .p_da1(p_da1), .p_da2(p_da2), .p_da3(p_da3),
    .p_da4(p_da4), .turn(turn), .busy(busy), .done(done)
  );

  assign pda_vec = {p_da4, p_da3, p_da2, p_da1};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int players(input logic [2:0] n);
    return (n == 3'd2 || n == 3'd3) ? int'(n) : 4;
  endfunction

  function automatic int model_next(input int t, input bit keep, input logic [2:0] n);
    int np;
    np = players(n);
    if (t >= np) return 0;
    return keep ? t : (t + 1) % np;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".D"}, D, 1'b0);
    chk({tag, ".pda"}, pda_vec, 4'b0000);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".turn"}, turn, model_turn[1:0]);
  endtask

  // One full move; the expected waveform is built from the move length alone.
  task automatic do_move(input string tag, input int k, input bit kp, input bit junk);
    int len;
    int pulses;
    bit step;
    pulses = 0;
    len = GAP_EN ? ((k == 0) ? 0 : 2 * k - 1) : k;
    move_req = 1'b1; steps = k[2:0]; keep_turn = kp;
    tick();
    move_req = 1'b0; steps = 3'($urandom_range(7)); keep_turn = 1'($urandom_range(1));
    for (int c = 0; c <= len; c++) begin
      step = (c < len) && (!GAP_EN || (c % 2 == 0));
      if (D === 1'b1) pulses++;
      chk({tag, ".D"}, D, step);
      chk({tag, ".pda"}, pda_vec, step ? (4'b0001 << model_turn) : 4'b0000);
      chk({tag, ".busy"}, busy, 1'b1);
      chk({tag, ".done"}, done, c == len);
      if (junk && c < len) begin
        move_req = 1'b1; steps = 3'd7;
      end else begin
        move_req = 1'b0;
      end
      tick();
    end
    move_req = 1'b0;
    chk({tag, ".pulses"}, pulses, k);
    model_turn = model_next(model_turn, kp, N);
    chk_idle({tag, ".end"});
  endtask

  task automatic do_setup(input string tag);
    M = 3'b010;
    tick();
    M = 3'b000;
    model_turn = 0;
    chk_idle(tag);
  endtask

  initial begin
    rst_n = 1'b0; M = 3'b000; N = 3'd4; move_req = 1'b0; steps = 3'd0; keep_turn = 1'b0;
    #3;
    chk_idle("reset");
    #4 rst_n = 1'b1;
    tick();
    chk_idle("post_reset");

    // Basic gapped move from player 1.
    N = 3'd4;
    do_move("n4_s3", 3, 1'b0, 1'b0);
    chk("n4_s3.turn1", turn, 2'd1);

    // Three-player rotation with wrap.
    do_setup("setup0");
    N = 3'd3;
    for (int i = 0; i < 4; i++) do_move("n3_rot", 1, 1'b0, 1'b0);
    chk("n3_rot.turn", turn, 2'd1);

    do_move("zero_steps", 0, 1'b0, 1'b0);
    do_move("keep5", 5, 1'b1, 1'b0);
    do_move("ignore_busy", 4, 1'b0, 1'b1);

    // Setup mode aborts a move after its second pulse.
    begin
      int second;
      second = GAP_EN ? 2 : 1;
      N = 3'd4;
      move_req = 1'b1; steps = 3'd5; keep_turn = 1'b0;
      tick();
      move_req = 1'b0;
      for (int c = 0; c < second; c++) tick();
      chk("abort.second_pulse", D, 1'b1);
      M = 3'b010;
      tick();
      model_turn = 0;
      chk_idle("abort");
      move_req = 1'b1; steps = 3'd3;
      tick();
      move_req = 1'b0;
      chk_idle("abort.req_ignored");
      tick();
      chk("abort.no_done", done, 1'b0);
      M = 3'b000;
    end

    // Player count shrinks under a stranded turn.
    N = 3'd4;
    for (int i = 0; i < 3; i++) do_move("climb", 1, 1'b0, 1'b0);
    chk("climb.turn3", turn, 2'd3);
    N = 3'd2;
    do_move("shrink_keep", 2, 1'b1, 1'b0);
    chk("shrink_keep.turn0", turn, 2'd0);
    N = 3'd7;
    do_move("invalid_n", 1, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      N = 3'($urandom_range(7));
      do_move("rand", $urandom_range(7), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    // Asynchronous reset in the middle of a move.
    move_req = 1'b1; steps = 3'd6; keep_turn = 1'b0;
    tick();
    move_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    model_turn = 0;
    chk_idle("async_reset");
    rst_n = 1'b1;
    tick();
    chk_idle("after_async_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
